// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, byte indexing, FSM states and inverse S-box table
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Byte k = 4c + r, so the index is simply {c, r}.
    function automatic logic [3:0] byte_idx(input logic [1:0] r, input logic [1:0] c);
        return {c, r};
    endfunction

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_shift_serial.sv
// rtl/inv_sub_shift_serial.sv - InvShiftRows + InvSubBytes, column-serial (INV_SUB_SHIFT_PARALLEL_EN: all 16 bytes at once)
module inv_sub_shift_serial
    import aes_pkg::*;
#(
    parameter bit SCRUB_ON_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    fsm_state_e state_q, state_d;
    state_t     cap_q, cap_d;
    state_t     out_q, out_d;

`ifdef INV_SUB_SHIFT_PARALLEL_EN
    state_t par_word;

    // out(r,c) reads in(r,(c-r) mod 4); all indices are elaboration-time constants.
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            inv_sbox u_inv_sbox (
                .in_byte  (cap_q[8*(4*((c - r + 4) % 4) + r) +: 8]),
                .out_byte (par_word[8*(4*c + r) +: 8])
            );
        end
    end
`else
    logic [1:0]  col_q, col_d;
    byte_t       sb_in  [N_ROWS];
    byte_t       sb_out [N_ROWS];
    logic [31:0] col_word;

    // Row r of output column col comes from source column col-r, 2-bit wrap.
    always_comb begin
        for (int r = 0; r < N_ROWS; r++) begin
            sb_in[r] = cap_q[{byte_idx(2'(r), col_q - 2'(r)), 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < N_ROWS; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (sb_in[g]),
            .out_byte (sb_out[g])
        );
    end

    assign col_word = {sb_out[3], sb_out[2], sb_out[1], sb_out[0]};
`endif

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
        col_d     = col_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap_d   = in_state;
                    state_d = BUSY;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
                    col_d   = 2'd0;
`endif
                end
            end
            BUSY: begin
`ifdef INV_SUB_SHIFT_PARALLEL_EN
                out_d   = par_word;
                state_d = DONE;
`else
                out_d[{col_q, 5'b00000} +: 32] = col_word;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    if (SCRUB_ON_IDLE) begin
                        out_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            out_q   <= '0;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
            col_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
            col_q   <= col_d;
`endif
        end
    end

    assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// tb/tb_inv_sub_shift_serial.sv - self-checking bench for inv_sub_shift_serial
module tb_inv_sub_shift_serial;

`ifdef INV_SUB_SHIFT_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int CPB   = LAT + 2;
    localparam bit SCRUB = 1'b1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int n_checks;
    int n_errors;

    logic [7:0] isb [256];

    inv_sub_shift_serial #(.SCRUB_ON_IDLE(SCRUB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(4*c + r) +: 8] = isb[s[8*(4*((c - r + 4) % 4) + r) +: 8]];
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer s, wait for the result, complete the output handshake; lat = accept edge to out_valid.
    task automatic run_block(input logic [127:0] s, output logic [127:0] res, output int lat);
        int n;
        in_state = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        res = out_state;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_in_ready", {127'b0, in_ready}, 128'd1);
        chk("post_hs_out_valid", {127'b0, out_valid}, 128'd0);
        chk("post_hs_out_state", out_state, SCRUB ? 128'h0 : res);
    endtask

    typedef struct {
        logic [127:0] in_s;
        logic [127:0] exp_s;
        string        name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] res, s1, s2, v;
        logic [127:0] bb [3];
        logic [127:0] exp_q [$];
        int           lat, idx, outs, last_acc;
        int           rr [4];
        int           cc [4];

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;

        for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);

        vecs[0] = '{128'h0, {16{8'h52}}, "all_zero"};
        vecs[1] = '{{16{8'h63}}, 128'h0, "all_63"};
        rr = '{1, 2, 3, 3};
        cc = '{0, 0, 0, 2};
        for (int i = 0; i < 4; i++) begin
            v = {16{8'h7c}};
            v[8*(4*cc[i] + rr[i]) +: 8] = 8'h63;
            vecs[i+2].in_s  = v;
            v = {16{8'h01}};
            v[8*(4*((cc[i] + rr[i]) % 4) + rr[i]) +: 8] = 8'h00;
            vecs[i+2].exp_s = v;
            vecs[i+2].name  = $sformatf("shift_r%0d_c%0d", rr[i], cc[i]);
        end

        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_in_ready", {127'b0, in_ready}, 128'd1);
        chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
        chk("reset_out_state", out_state, 128'h0);

        foreach (vecs[i]) begin
            run_block(vecs[i].in_s, res, lat);
            chk(vecs[i].name, res, vecs[i].exp_s);
            chk({vecs[i].name, "_latency"}, 128'(lat), 128'(LAT));
        end

        // Reset while busy: the in-flight block must vanish without a valid pulse.
        in_state = {4{$urandom}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_out_state", out_state, 128'h0);
        rst_n = 1'b1;
        s1 = {$urandom, $urandom, $urandom, $urandom};
        run_block(s1, res, lat);
        chk("midrst_next_block", res, model(s1));
        chk("midrst_next_latency", 128'(lat), 128'(LAT));

        // Backpressure with in_valid high throughout.
        s1 = {$urandom, $urandom, $urandom, $urandom};
        s2 = {$urandom, $urandom, $urandom, $urandom};
        in_state = s1;
        in_valid = 1'b1;
        tick();
        in_state = s2;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("bp_latency", 128'(lat), 128'(LAT));
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
            chk("bp_out_state", out_state, model(s1));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_in_ready", {127'b0, in_ready}, 128'd1);
        chk("bp_rel_out_valid", {127'b0, out_valid}, 128'd0);
        chk("bp_rel_out_state", out_state, SCRUB ? 128'h0 : model(s1));
        tick();
        in_valid = 1'b0;
        chk("bp_next_accepted", {127'b0, in_ready}, 128'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("bp_next_latency", 128'(lat), 128'(LAT));
        chk("bp_next_state", out_state, model(s2));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back: in_valid and out_ready held high.
        for (int i = 0; i < 3; i++) bb[i] = {$urandom, $urandom, $urandom, $urandom};
        idx = 0;
        outs = 0;
        last_acc = -1;
        in_state = bb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && outs < 3; cyc++) begin
            if (in_valid && in_ready) begin
                if (last_acc >= 0) chk("b2b_spacing", 128'(cyc - last_acc), 128'(CPB));
                last_acc = cyc;
                exp_q.push_back(model(bb[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected_output", 128'd1, 128'd0);
                end else begin
                    chk($sformatf("b2b_out%0d", outs), out_state, exp_q.pop_front());
                end
                outs++;
            end
            tick();
            if (idx < 3) in_state = bb[idx];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", 128'(outs), 128'd3);

        for (int i = 0; i < 20; i++) begin
            s1 = {$urandom, $urandom, $urandom, $urandom};
            run_block(s1, res, lat);
            chk($sformatf("rand%0d", i), res, model(s1));
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(LAT));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_sub_shift_serial.md
Name: inv_sub_shift_serial

Overview:
- Sequential InvShiftRows + InvSubBytes stage of the AES inverse-cipher datapath.
- Sits directly downstream of inv_mix_column. It consumes the 128-bit InvMixColumns result and produces the state for the next round's AddRoundKey.
- Uses a column-serial datapath: 4 inverse S-boxes, one output column per cycle. A valid/ready handshake on both sides lets the round controller stall it.

Parameters:
- SCRUB_ON_IDLE, 1, when 1 the result register is cleared to 128'h0 on the DONE->IDLE transition; when 0 it holds its last value.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input state. Byte k=4c+r (row r, column c) sits at bits [8k+7:8k], same packing as inv_mix_column.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  InvSubBytes(InvShiftRows(in_state)), same packing.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE and the column counter to 0.
  - out_valid=0; out_state and the captured-input register are cleared to 0.
  - Reset takes priority over every other event, including mid-BUSY or mid-DONE; the in-flight block is discarded and no partial output is ever flagged valid.
- Transform:
  - out(r,c) = InvSbox(in(r,(c-r) mod 4)), for r,c in 0..3.
  - Column index arithmetic is 2-bit and wraps naturally.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture in_state, set col=0, go to BUSY.
- BUSY state:
  - in_ready=0, out_valid=0.
  - Each cycle: gather the 4 bytes of output column col from the captured register via the shift mapping, pass them through the 4 inverse S-boxes, write out_state[32col+31:32col], then col++.
  - After the col=3 write, go to DONE.
  - in_valid is ignored while in BUSY.
- DONE state:
  - out_valid=1, in_ready=0.
  - out_state is stable and fully written.
  - On out_ready=1: go to IDLE, clearing out_state if SCRUB_ON_IDLE=1.
  - If out_ready=0: hold indefinitely.
- Latency and throughput:
  - Accept edge E0; columns written at E1..E4; out_valid=1 from E4.
  - Next accept no earlier than one cycle after the output handshake, giving a minimum of 6 cycles per block.
- Simultaneous events:
  - An output handshake and in_valid in the same cycle do not accept the new block; it is accepted in the following IDLE cycle.
- out_state bytes for unwritten columns during BUSY are don't-care to consumers, since out_valid=0.

Optional Feature:
- Macro: INV_SUB_SHIFT_PARALLEL_EN.
- Defined:
  - 16 inverse S-boxes are instantiated and all columns are written at E1; BUSY lasts exactly 1 cycle.
  - out_valid=1 from E1; minimum 3 cycles per block.
  - Handshake, reset and scrub rules are unchanged.
- Undefined: the 4-S-box column-serial behaviour described above.

Decomposition:
- Shared package aes_pkg holds:
  - state_t (128-bit) and byte_t typedefs;
  - the byte-index helper constant (k=4c+r);
  - the FSM state enum (IDLE, BUSY, DONE);
  - the 256-entry inverse S-box table constant.
- Sub-module inv_sbox: purely combinational, 8-bit in and 8-bit out, looking up the aes_pkg table. It is instantiated 4 times, or 16 times with the macro.

Test Plan:
- Reset mid-BUSY: accept a block, assert rst_n=0 at E2 -> next cycle in_ready=1, out_valid=0, out_state=0; the following block is processed cleanly.
- All-zero input: in_state=128'h0 -> out_state = sixteen bytes of 8'h52, with out_valid rising exactly 4 edges after accept (1 edge with the macro).
- All-0x63 input: in_state = sixteen bytes of 8'h63 -> out_state=128'h0.
- Shift mapping: every byte 8'h7c except byte1 (r=1,c=0)=8'h63 -> every output byte 8'h01 except byte5 (r=1,c=1)=8'h00. Repeat with the unique byte at row 2 and at row 3; the 8'h00 lands at column (c+r) mod 4.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready=0 despite in_valid=1. Release -> IDLE next cycle; out_state=0 if SCRUB_ON_IDLE=1, held if 0.
- Back-to-back: in_valid held high with 3 distinct states and out_ready=1 -> accepts exactly 6 cycles apart, with outputs in order and matching the golden model.
